// File: rtl/native_bus_pkg.sv
// Shared definitions for the picorv32 native-bus memory/MMIO slave.
// Contents:
//   state_t        transaction FSM states (IDLE -> WAIT -> RESP)
//   region_t       address decode result (RAM / GPIO / CYCLE / ERR)
//   MMIO_*_OFS     register offsets inside the MMIO window
//   WAIT_CNT_W     width of the wait-state counter (WAIT_CYCLES is 0..15)
//   decode_region  maps a latched request onto a region
package native_bus_pkg;

    localparam int          WAIT_CNT_W     = 4;
    localparam logic [31:0] MMIO_GPIO_OFS  = 32'h0000_0000;
    localparam logic [31:0] MMIO_CYCLE_OFS = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_GPIO,
        RGN_CYCLE,
        RGN_ERR
    } region_t;

    // Misalignment is an error everywhere. Instruction fetches are legal
    // from RAM only; the MMIO registers are data-only.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic        instr,
        input logic [31:0] ram_bytes,
        input logic [31:0] mmio_base
    );
        region_t rgn;
        rgn = RGN_ERR;
        if (addr[1:0] != 2'b00) begin
            rgn = RGN_ERR;
        end else if (addr < ram_bytes) begin
            rgn = RGN_RAM;
        end else if (instr) begin
            rgn = RGN_ERR;
        end else if (addr == mmio_base + MMIO_GPIO_OFS) begin
            rgn = RGN_GPIO;
        end else if (addr == mmio_base + MMIO_CYCLE_OFS) begin
            rgn = RGN_CYCLE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/native_mem_slave_if.sv
// picorv32 native memory bus bundle.
//   mem_valid  master -> slave  request valid, held until mem_ready
//   mem_instr  master -> slave  request is an instruction fetch
//   mem_addr   master -> slave  byte address
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte-lane write strobes, 0 = read
//   mem_ready  slave -> master  one-cycle completion pulse
//   mem_rdata  slave -> master  read data, valid while mem_ready = 1
interface native_mem_slave_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/native_mem_ram.sv
// Single-port synchronous-read RAM, 32-bit words with four byte-lane write
// enables. Read-first: a cycle that writes returns the word as it was
// before the write. Contents are never reset.
// Ports:
//   clk    clock
//   en     port enable (read and/or write this cycle)
//   we     per-byte write enables, only honoured when en = 1
//   addr   word index
//   wdata  write data
//   rdata  registered read data, holds while en = 0
module native_mem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter     INIT_FILE   = "",
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/native_mem_slave.sv
// Memory/MMIO slave for the picorv32 native bus: RAM, a GPIO output
// register, a free-running cycle counter and a sticky bus-error report.
// Ports:
//   clk       clock, all state on the rising edge
//   reset     asynchronous active-high reset
//   bus       native bus, slave side
//   gpio_out  GPIO output register (MMIO_BASE)
//   bus_err   sticky illegal-access flag, cleared only by reset
//   err_addr  address of the first illegal access
// Timing: a request accepted on edge N is served in RESP (after edge
// N+WAIT_CYCLES) and mem_ready is high for the one cycle after edge
// N+1+WAIT_CYCLES. The RAM is read on the accept edge itself so its
// registered output is ready by RESP; writes commit at the end of RESP.
module native_mem_slave
    import native_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    native_mem_slave_if.slave    bus,
    output logic [31:0]          gpio_out,
    output logic                 bus_err,
    output logic [31:0]          err_addr
);

    localparam int                    AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0]           RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  state_reg, state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [31:0]             addr_reg;
    logic [31:0]             wdata_reg;
    logic [3:0]              wstrb_reg;
    logic                    instr_reg;
    logic                    ready_reg;
    logic [31:0]             rdata_reg;
    logic [31:0]             cycle_reg;
    logic                    bus_err_reg;
    logic [31:0]             err_addr_reg;

    logic                    accept;
    logic                    in_resp;
    region_t                 region;
    logic                    ram_en;
    logic [3:0]              ram_we;
    logic [AW-1:0]           ram_addr;
    logic [31:0]             ram_q;

    // The !ready_reg guard stops the request that is still being held on
    // the bus during the mem_ready cycle from being accepted a second time.
    assign accept  = (state_reg == ST_IDLE) && bus.mem_valid && !ready_reg;
    assign in_resp = (state_reg == ST_RESP);
    assign region  = decode_region(addr_reg, instr_reg, RAM_BYTES, MMIO_BASE);

    // Read on acceptance straight from the bus address, write in RESP from
    // the latched request; the two never coincide.
    assign ram_we   = (in_resp && region == RGN_RAM) ? wstrb_reg : 4'b0000;
    assign ram_en   = accept || (|ram_we);
    assign ram_addr = accept ? bus.mem_addr[2 +: AW] : addr_reg[2 +: AW];

    native_mem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_reg),
        .rdata (ram_q)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    wait_cnt_next = '0;
                    state_next    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            instr_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                addr_reg  <= bus.mem_addr;
                wdata_reg <= bus.mem_wdata;
                wstrb_reg <= bus.mem_wstrb;
                instr_reg <= bus.mem_instr;
            end
        end
    end

    // Response, counter and error reporting. Reads always return the
    // pre-write value; erroring accesses return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_reg    <= 1'b0;
            rdata_reg    <= '0;
            cycle_reg    <= '0;
            bus_err_reg  <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            ready_reg <= in_resp;
            if (in_resp) begin
                case (region)
                    RGN_RAM:   rdata_reg <= ram_q;
                    RGN_GPIO:  rdata_reg <= gpio_out;
                    RGN_CYCLE: rdata_reg <= cycle_reg;
                    default:   rdata_reg <= '0;
                endcase
                if (region == RGN_ERR) begin
                    bus_err_reg <= 1'b1;
                    if (!bus_err_reg) begin
                        err_addr_reg <= addr_reg;
                    end
                end
            end
        end
    end

    // GPIO register, one byte lane per generated block.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gpio
            logic [7:0] byte_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    byte_reg <= '0;
                end else if (in_resp && region == RGN_GPIO && wstrb_reg[gi]) begin
                    byte_reg <= wdata_reg[gi*8 +: 8];
                end
            end
            assign gpio_out[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    assign bus.mem_ready = ready_reg;
    assign bus.mem_rdata = rdata_reg;
    assign bus_err       = bus_err_reg;
    assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_native_mem_slave.sv
// Bench for native_mem_slave: one instance with no wait states, one with
// three. Expected values come from a word-array model of the RAM and from
// the latency/decode rules of the slave.
module tb_native_mem_slave;

    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   checks = 0;
    int   errors = 0;
    int   tb_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    native_mem_slave_if b0();
    native_mem_slave_if b3();

    logic [31:0] gpio0, gpio3, eaddr0, eaddr3;
    logic        err0, err3;

    native_mem_slave #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (0),
        .MMIO_BASE   (MMIO_BASE),
        .INIT_FILE   ("")
    ) dut0 (
        .clk      (clk),
        .reset    (rst0),
        .bus      (b0),
        .gpio_out (gpio0),
        .bus_err  (err0),
        .err_addr (eaddr0)
    );

    native_mem_slave #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (3),
        .MMIO_BASE   (MMIO_BASE),
        .INIT_FILE   ("")
    ) dut3 (
        .clk      (clk),
        .reset    (rst3),
        .bus      (b3),
        .gpio_out (gpio3),
        .bus_err  (err3),
        .err_addr (eaddr3)
    );

    logic [31:0] model0 [256];
    logic [31:0] model3 [256];

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? b3.mem_ready : b0.mem_ready;
    endfunction

    function automatic logic [31:0] rdat(input int sel);
        return (sel != 0) ? b3.mem_rdata : b0.mem_rdata;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic i);
        if (sel != 0) begin
            b3.mem_valid = v; b3.mem_addr = a; b3.mem_wdata = d; b3.mem_wstrb = s; b3.mem_instr = i;
        end else begin
            b0.mem_valid = v; b0.mem_addr = a; b0.mem_wdata = d; b0.mem_wstrb = s; b0.mem_instr = i;
        end
    endtask

    // Called #1 after a rising edge. Holds the request until mem_ready is
    // seen, keeps it through the handshake edge, then releases the bus.
    task automatic bus_txn(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input bit drop,
                           output logic [31:0] rdata, output int lat,
                           output logic ready_after, output logic [31:0] gpio_at);
        bit seen;
        seen = 0;
        lat = 0;
        rdata = '0;
        gpio_at = '0;
        drive(sel, 1'b1, addr, wdata, wstrb, instr);
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1 && drop) drive(sel, 1'b0, $urandom, $urandom, 4'($urandom), 1'b0);
            if (rdy(sel)) seen = 1;
        end
        if (!seen) lat = -1;
        rdata = rdat(sel);
        gpio_at = (sel != 0) ? gpio3 : gpio0;
        @(posedge clk); #1;
        ready_after = rdy(sel);
        drive(sel, 1'b0, '0, '0, 4'h0, 1'b0);
        $display("txn dut%0d addr=%08h wdata=%08h wstrb=%b instr=%0d drop=%0d -> rdata=%08h lat=%0d",
                 sel, addr, wdata, wstrb, instr, drop, rdata, lat);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, '0, '0, 4'h0, 1'b0);
        drive(1, 1'b0, '0, '0, 4'h0, 1'b0);
        rst0 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b0.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", b0.mem_ready); end
        checks++; if (b0.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%08h exp=0", b0.mem_rdata); end
        checks++; if (gpio0 !== 32'h0) begin errors++; $display("FAIL reset_gpio0 got=%08h exp=0", gpio0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got=%b exp=0", err0); end
        checks++; if (eaddr0 !== 32'h0) begin errors++; $display("FAIL reset_eaddr0 got=%08h exp=0", eaddr0); end
        checks++; if (b3.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready3 got=%b exp=0", b3.mem_ready); end
        checks++; if (b3.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got=%08h exp=0", b3.mem_rdata); end
        checks++; if (gpio3 !== 32'h0) begin errors++; $display("FAIL reset_gpio3 got=%08h exp=0", gpio3); end
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, ga, d, exp_w;
        logic [3:0]  strb;
        logic        ra, instr;
        bit          drop;
        int          lat, idx, w;
        for (int s = 0; s < 2; s++) begin
            w = (s != 0) ? 3 : 0;
            for (int i = 0; i < 17; i++) begin
                idx = (i < 16) ? i : 255;
                d = $urandom;
                bus_txn(s, 32'(idx * 4), d, 4'hF, 1'b0, 0, rd, lat, ra, ga);
                if (s != 0) model3[idx] = d; else model0[idx] = d;
            end
            for (int n = 0; n < 40; n++) begin
                idx   = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 15);
                strb  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                d     = $urandom;
                instr = (strb == 4'h0) ? 1'($urandom) : 1'b0;
                drop  = ($urandom_range(0, 3) == 0);
                exp_w = (s != 0) ? model3[idx] : model0[idx];
                bus_txn(s, 32'(idx * 4), d, strb, instr, drop, rd, lat, ra, ga);
                checks++; if (rd !== exp_w) begin errors++; $display("FAIL rand_rdata dut%0d idx=%0d got=%08h exp=%08h", s, idx, rd, exp_w); end
                checks++; if (lat !== w + 2) begin errors++; $display("FAIL rand_latency dut%0d got=%0d exp=%0d", s, lat, w + 2); end
                checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rand_ready_pulse dut%0d got=%b exp=0", s, ra); end
                if (s != 0) model3[idx] = merge_word(exp_w, d, strb);
                else        model0[idx] = merge_word(exp_w, d, strb);
            end
        end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rand_no_err0 got=%b exp=0", err0); end
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rand_no_err3 got=%b exp=0", err3); end
    endtask

    task automatic test_full_write();
        logic [31:0] rd, ga;
        logic        ra;
        int          lat;
        bus_txn(0, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (lat !== 2) begin errors++; $display("FAIL full_wr_latency got=%0d exp=2", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL full_wr_pulse got=%b exp=0", ra); end
        model0[4] = 32'hDEAD_BEEF;
        bus_txn(0, 32'h10, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_rd_data got=%08h exp=deadbeef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL full_rd_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd, ga;
        logic        ra;
        int          lat;
        bus_txn(0, 32'h10, 32'h0000_AB00, 4'b0010, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lane_prewrite got=%08h exp=deadbeef", rd); end
        bus_txn(0, 32'h10, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== 32'hDEAD_ABEF) begin errors++; $display("FAIL lane_readback got=%08h exp=deadabef", rd); end
        model0[4] = 32'hDEAD_ABEF;
    endtask

    task automatic test_wait_latency();
        logic [31:0] rd, ga;
        logic        ra;
        int          lat;
        bus_txn(1, 32'h0, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wait_latency got=%0d exp=5", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wait_pulse got=%b exp=0", ra); end
        checks++; if (rd !== model3[0]) begin errors++; $display("FAIL wait_rdata got=%08h exp=%08h", rd, model3[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ga;
        logic        ra;
        int          lat, c0, idx;
        c0 = tb_cyc;
        for (int n = 0; n < 4; n++) begin
            idx = $urandom_range(0, 15);
            bus_txn(1, 32'(idx * 4), 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
            checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency n=%0d got=%0d exp=5", n, lat); end
            checks++; if (rd !== model3[idx]) begin errors++; $display("FAIL b2b_rdata n=%0d got=%08h exp=%08h", n, rd, model3[idx]); end
        end
        checks++; if (tb_cyc - c0 !== 24) begin errors++; $display("FAIL b2b_span got=%0d exp=24", tb_cyc - c0); end
    endtask

    task automatic test_mmio();
        logic [31:0] rd, ga, gpio_m, cyc_a, cyc_b;
        logic        ra;
        int          lat, ta, tb, k;
        gpio_m = merge_word(32'h0, 32'h0000_005A, 4'b0001);
        bus_txn(0, MMIO_BASE, 32'h0000_005A, 4'b0001, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (ga !== gpio_m) begin errors++; $display("FAIL gpio_with_ready got=%08h exp=%08h", ga, gpio_m); end
        bus_txn(0, MMIO_BASE, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== gpio_m) begin errors++; $display("FAIL gpio_readback got=%08h exp=%08h", rd, gpio_m); end
        gpio_m = merge_word(gpio_m, 32'hCAFE_1200, 4'b1110);
        bus_txn(0, MMIO_BASE, 32'hCAFE_1200, 4'b1110, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (gpio0 !== gpio_m) begin errors++; $display("FAIL gpio_lanes got=%08h exp=%08h", gpio0, gpio_m); end
        ta = tb_cyc;
        bus_txn(0, MMIO_BASE + 32'h4, 32'h0, 4'b0000, 1'b0, 0, cyc_a, lat, ra, ga);
        k = $urandom_range(1, 20);
        repeat (k) @(posedge clk);
        #1;
        tb = tb_cyc;
        bus_txn(0, MMIO_BASE + 32'h4, 32'h0, 4'b0000, 1'b0, 0, cyc_b, lat, ra, ga);
        checks++; if (cyc_b - cyc_a !== 32'(tb - ta)) begin errors++; $display("FAIL cycle_delta got=%0d exp=%0d", cyc_b - cyc_a, tb - ta); end
        bus_txn(0, MMIO_BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL cycle_write_no_err got=%b exp=0", err0); end
        checks++; if (gpio0 !== gpio_m) begin errors++; $display("FAIL cycle_write_gpio got=%08h exp=%08h", gpio0, gpio_m); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, ga, gpio_m;
        logic        ra;
        int          lat;
        gpio_m = gpio0 === 32'hCAFE_125A ? 32'hCAFE_125A : 32'hCAFE_125A;
        bus_txn(0, 32'h3FC, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== model0[255]) begin errors++; $display("FAIL last_word got=%08h exp=%08h", rd, model0[255]); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL last_word_err got=%b exp=0", err0); end
        bus_txn(0, 32'h400, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata got=%08h exp=0", rd); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", err0); end
        checks++; if (eaddr0 !== 32'h400) begin errors++; $display("FAIL err_addr got=%08h exp=00000400", eaddr0); end
        bus_txn(0, 32'h802, 32'h1234_5678, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (lat !== 2) begin errors++; $display("FAIL err2_latency got=%0d exp=2", lat); end
        checks++; if (eaddr0 !== 32'h400) begin errors++; $display("FAIL err_first_wins got=%08h exp=00000400", eaddr0); end
        bus_txn(0, 32'h0, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== model0[0]) begin errors++; $display("FAIL err_ram_untouched got=%08h exp=%08h", rd, model0[0]); end
        bus_txn(0, 32'h12, 32'h8765_4321, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        bus_txn(0, 32'h10, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== model0[4]) begin errors++; $display("FAIL misaligned_dropped got=%08h exp=%08h", rd, model0[4]); end
        bus_txn(0, MMIO_BASE, 32'h0, 4'b0000, 1'b1, 0, rd, lat, ra, ga);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ifetch_mmio_rdata got=%08h exp=0", rd); end
        bus_txn(0, MMIO_BASE + 32'h8, 32'h0BAD_0BAD, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (gpio0 !== gpio_m) begin errors++; $display("FAIL unmapped_gpio got=%08h exp=%08h", gpio0, gpio_m); end
        checks++; if (err0 !== 1'b1 || eaddr0 !== 32'h400) begin errors++; $display("FAIL err_sticky got=%b/%08h exp=1/00000400", err0, eaddr0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ga, a_val;
        logic        ra;
        int          lat;
        bit          stray;
        a_val = $urandom | 32'h1;
        bus_txn(1, MMIO_BASE, 32'h0000_0077, 4'b0001, 1'b0, 0, rd, lat, ra, ga);
        bus_txn(1, 32'h20, a_val, 4'b1111, 1'b0, 0, rd, lat, ra, ga);
        model3[8] = a_val;
        bus_txn(1, 32'h20, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        drive(1, 1'b1, 32'h20, ~a_val, 4'b1111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b1;
        #1;
        checks++; if (b3.mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", b3.mem_ready); end
        checks++; if (b3.mem_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%08h exp=0", b3.mem_rdata); end
        checks++; if (gpio3 !== 32'h0) begin errors++; $display("FAIL midrst_gpio got=%08h exp=0", gpio3); end
        drive(1, 1'b0, '0, '0, 4'h0, 1'b0);
        stray = 0;
        repeat (2) begin @(posedge clk); #1; if (b3.mem_ready) stray = 1; end
        rst3 = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (b3.mem_ready) stray = 1; end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL midrst_no_ready got=%b exp=0", stray); end
        bus_txn(1, 32'h20, 32'h0, 4'b0000, 1'b0, 0, rd, lat, ra, ga);
        checks++; if (rd !== a_val) begin errors++; $display("FAIL midrst_write_discarded got=%08h exp=%08h", rd, a_val); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_recover_latency got=%0d exp=5", lat); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_full_write();
        test_byte_lane();
        test_wait_latency();
        test_back_to_back();
        test_mmio();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", tb_cyc);
        $fatal(1, "watchdog");
    end

endmodule
